// File: rtl/ahb_uart_pkg.sv
// Shared definitions for the bus-attached UART: register decode, bit positions
// and the transmit sequencer states.
package ahb_uart_pkg;

  typedef enum logic [2:0] {
    ADDR_STATUS   = 3'd0,
    ADDR_CTRL     = 3'd1,
    ADDR_RXDATA   = 3'd2,
    ADDR_TXDATA   = 3'd3,
    ADDR_IRQ_EN   = 3'd4,
    ADDR_IRQ_STAT = 3'd5
  } reg_addr_e;

  localparam int CTRL_RX_EN    = 16;
  localparam int CTRL_TX_EN    = 17;
  localparam int CTRL_RX_FLUSH = 18;
  localparam int CTRL_TX_FLUSH = 19;

  localparam int STAT_RX_EMPTY = 0;
  localparam int STAT_RX_FULL  = 1;
  localparam int STAT_TX_EMPTY = 2;
  localparam int STAT_TX_FULL  = 3;
  localparam int STAT_TX_BUSY  = 4;

  localparam int IRQ_RX_NONEMPTY = 0;
  localparam int IRQ_TX_IDLE     = 1;
  localparam int IRQ_RX_ERR      = 2;
  localparam int IRQ_RX_OVF      = 3;
  localparam int IRQ_TX_OVF      = 4;
  localparam int IRQ_W           = 5;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_LOAD = 2'd1,
    TX_SEND = 2'd2
  } tx_state_e;

  function automatic logic [7:0] sat8(input logic [8:0] c);
    return (c > 9'd255) ? 8'hFF : c[7:0];
  endfunction

endpackage

// File: rtl/bus_protocol_if.sv
// Simple single-cycle register bus; the peripheral never stalls.
interface bus_protocol_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [3:0]  strobe;
  logic        ren;
  logic        wen;
  logic        error;
  logic        request_stall;

  modport peripheral_vital (
    input  addr, wdata, strobe, ren, wen,
    output rdata, error, request_stall
  );

  modport vital (
    output addr, wdata, strobe, ren, wen,
    input  rdata, error, request_stall
  );
endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with naturally wrapping pointers and an explicit occupancy count.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     nReset,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the same cycle frees a slot.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!nReset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ahb_uart_fifo.sv
// UART peripheral: register file, RX/TX FIFOs, 8N1 serial engines and TX sequencer.
// TX sequencer states:
//   TX_IDLE | waiting for tx_en and a queued byte
//   TX_LOAD | latch FIFO head, pop it, pulse tx_valid
//   TX_SEND | engine shifting the byte out, wait for tx_done
module ahb_uart_fifo
  import ahb_uart_pkg::*;
#(
  parameter logic [15:0] DEFAULT_RATE = 16'd5207,
  parameter int          RX_DEPTH     = 16,
  parameter int          TX_DEPTH     = 16
) (
  input  logic clk,
  input  logic nReset,
  input  logic rx,
  output logic tx,
  output logic irq,
  bus_protocol_if.peripheral_vital bp
);
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int TX_AW = $clog2(TX_DEPTH);

  logic [2:0]  widx;
  logic        mapped;
  logic        rd_hit, wr_hit;
  logic        ctrl_wr, txdata_wr, irqen_wr, irqstat_wr, rxdata_rd;
  logic [15:0] rate, rate_next, rate_m1;
  logic        rx_en, tx_en, eng_hold, eng_rst;
  logic        rx_flush, tx_flush;
  logic [IRQ_W-1:0] irq_en, irq_stat, w1c;
  logic        rx_err_f, rx_ovf_f, tx_ovf_f;

  logic [7:0]       rx_head, tx_head;
  logic             rx_full, rx_empty, tx_full, tx_empty;
  logic [RX_AW:0]   rx_cnt;
  logic [TX_AW:0]   tx_cnt;
  logic             rx_push, rx_pop, tx_push, tx_pop;

  tx_state_e   tx_state;
  logic        tx_valid, tx_busy;
  logic [7:0]  tx_data;

  logic        tx_act, tx_done;
  logic [9:0]  tx_sh;
  logic [3:0]  tx_bits;
  logic [15:0] tx_tmr;

  logic        rx_s1, rx_s2, rx_act, rx_done, rx_err_p;
  logic [3:0]  rx_bits;
  logic [15:0] rx_tmr;
  logic [7:0]  rx_sh;

  logic        unused_bits;

  assign widx       = bp.addr[4:2];
  assign mapped     = (bp.addr[31:5] == '0) && (bp.addr[1:0] == 2'b00) && (widx <= 3'd5);
  assign rd_hit     = bp.ren && mapped;
  assign wr_hit     = bp.wen && mapped;
  assign ctrl_wr    = wr_hit && (widx == ADDR_CTRL);
  assign txdata_wr  = wr_hit && (widx == ADDR_TXDATA);
  assign irqen_wr   = wr_hit && (widx == ADDR_IRQ_EN);
  assign irqstat_wr = wr_hit && (widx == ADDR_IRQ_STAT);
  assign rxdata_rd  = rd_hit && (widx == ADDR_RXDATA);

  assign bp.error         = (bp.ren || bp.wen) && !mapped;
  assign bp.request_stall = 1'b0;
  assign unused_bits      = ^{bp.wdata[31:20], bp.strobe[3]};

  assign rate_next = {bp.strobe[1] ? bp.wdata[15:8] : rate[15:8],
                      bp.strobe[0] ? bp.wdata[7:0]  : rate[7:0]};
  assign rate_m1   = rate - 16'd1;
  assign rx_flush  = ctrl_wr && bp.strobe[2] && bp.wdata[CTRL_RX_FLUSH];
  assign tx_flush  = ctrl_wr && bp.strobe[2] && bp.wdata[CTRL_TX_FLUSH];
  assign eng_rst   = !nReset || eng_hold;
  assign w1c       = (irqstat_wr && bp.strobe[0]) ? bp.wdata[IRQ_W-1:0] : '0;

  always_ff @(posedge clk) begin
    if (!nReset) begin
      rate     <= DEFAULT_RATE;
      rx_en    <= 1'b1;
      tx_en    <= 1'b1;
      eng_hold <= 1'b0;
      irq_en   <= '0;
    end else begin
      eng_hold <= ctrl_wr && (bp.strobe[0] || bp.strobe[1]);
      if (ctrl_wr && (bp.strobe[0] || bp.strobe[1]))
        rate <= (rate_next == 16'd0) ? 16'd1 : rate_next;
      if (ctrl_wr && bp.strobe[2]) begin
        rx_en <= bp.wdata[CTRL_RX_EN];
        tx_en <= bp.wdata[CTRL_TX_EN];
      end
      if (irqen_wr && bp.strobe[0]) irq_en <= bp.wdata[IRQ_W-1:0];
    end
  end

  assign rx_push = rx_done && rx_en;
  assign rx_pop  = rxdata_rd;
  assign tx_push = txdata_wr && bp.strobe[0];
  assign tx_pop  = (tx_state == TX_LOAD) && !tx_empty;

  uart_sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .nReset(nReset), .flush(rx_flush),
    .push(rx_push), .pop(rx_pop), .wdata(rx_sh), .rdata(rx_head),
    .full(rx_full), .empty(rx_empty), .count(rx_cnt)
  );

  uart_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .nReset(nReset), .flush(tx_flush),
    .push(tx_push), .pop(tx_pop), .wdata(bp.wdata[7:0]), .rdata(tx_head),
    .full(tx_full), .empty(tx_empty), .count(tx_cnt)
  );

  // Set wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!nReset) begin
      rx_err_f <= 1'b0;
      rx_ovf_f <= 1'b0;
      tx_ovf_f <= 1'b0;
    end else begin
      rx_err_f <= rx_err_p || (rx_err_f && !w1c[IRQ_RX_ERR]);
      rx_ovf_f <= (rx_push && rx_full && !(rx_pop && !rx_empty)) ||
                  (rx_ovf_f && !w1c[IRQ_RX_OVF]);
      tx_ovf_f <= (tx_push && tx_full && !tx_pop) ||
                  (tx_ovf_f && !w1c[IRQ_TX_OVF]);
    end
  end

  assign tx_busy  = (tx_state != TX_IDLE);
  assign irq_stat = {tx_ovf_f, rx_ovf_f, rx_err_f, tx_empty && !tx_busy, !rx_empty};
  assign irq      = |(irq_stat & irq_en);

  always_comb begin
    bp.rdata = 32'h0;
    if (rd_hit) begin
      case (widx)
        ADDR_STATUS:   bp.rdata = {sat8(9'(rx_cnt)), sat8(9'(tx_cnt)), 11'b0,
                                   tx_busy, tx_full, tx_empty, rx_full, rx_empty};
        ADDR_CTRL:     bp.rdata = {14'b0, tx_en, rx_en, rate};
        ADDR_RXDATA:   bp.rdata = rx_empty ? 32'h8000_0000 : {24'b0, rx_head};
        ADDR_IRQ_EN:   bp.rdata = {{(32-IRQ_W){1'b0}}, irq_en};
        ADDR_IRQ_STAT: bp.rdata = {{(32-IRQ_W){1'b0}}, irq_stat};
        default:       bp.rdata = 32'h0;
      endcase
    end
  end

  // A rate change also resets the sequencer: the engine it waits on loses its frame.
  always_ff @(posedge clk) begin
    if (eng_rst) begin
      tx_state <= TX_IDLE;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      tx_valid <= 1'b0;
      case (tx_state)
        TX_IDLE: if (tx_en && !tx_empty) tx_state <= TX_LOAD;
        TX_LOAD: begin
          if (tx_empty) begin
            tx_state <= TX_IDLE;
          end else begin
            tx_data  <= tx_head;
            tx_valid <= 1'b1;
            tx_state <= TX_SEND;
          end
        end
        TX_SEND: if (tx_done) tx_state <= TX_IDLE;
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // TX engine: 10-bit 8N1 shifter, each bit held for rate clocks.
  always_ff @(posedge clk) begin
    if (eng_rst) begin
      tx_act  <= 1'b0;
      tx_done <= 1'b0;
      tx_sh   <= '1;
      tx_bits <= 4'd0;
      tx_tmr  <= 16'd0;
    end else begin
      tx_done <= 1'b0;
      if (!tx_act) begin
        if (tx_valid) begin
          tx_act  <= 1'b1;
          tx_sh   <= {1'b1, tx_data, 1'b0};
          tx_bits <= 4'd10;
          tx_tmr  <= rate_m1;
        end
      end else if (tx_tmr == 16'd0) begin
        tx_tmr  <= rate_m1;
        tx_sh   <= {1'b1, tx_sh[9:1]};
        tx_bits <= tx_bits - 4'd1;
        if (tx_bits == 4'd1) begin
          tx_act  <= 1'b0;
          tx_done <= 1'b1;
        end
      end else begin
        tx_tmr <= tx_tmr - 16'd1;
      end
    end
  end

  assign tx = !tx_act || tx_sh[0];

  // RX engine: sample mid-bit, start bit revalidated, bad stop bit reports an error.
  always_ff @(posedge clk) begin
    if (eng_rst) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_act   <= 1'b0;
      rx_done  <= 1'b0;
      rx_err_p <= 1'b0;
      rx_bits  <= 4'd0;
      rx_tmr   <= 16'd0;
      rx_sh    <= 8'h00;
    end else begin
      rx_s1    <= rx;
      rx_s2    <= rx_s1;
      rx_done  <= 1'b0;
      rx_err_p <= 1'b0;
      if (!rx_act) begin
        if (!rx_s2) begin
          rx_act  <= 1'b1;
          rx_bits <= 4'd0;
          rx_tmr  <= rate >> 1;
        end
      end else if (rx_tmr == 16'd0) begin
        rx_tmr <= rate_m1;
        if (rx_bits == 4'd0) begin
          if (rx_s2) rx_act <= 1'b0;
          else       rx_bits <= 4'd1;
        end else if (rx_bits <= 4'd8) begin
          rx_sh   <= {rx_s2, rx_sh[7:1]};
          rx_bits <= rx_bits + 4'd1;
        end else begin
          rx_act <= 1'b0;
          if (rx_s2) rx_done  <= 1'b1;
          else       rx_err_p <= 1'b1;
        end
      end else begin
        rx_tmr <= rx_tmr - 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_ahb_uart_fifo.sv
// Directed bench for ahb_uart_fifo: register table, serial frames, FIFO corners.
module tb_ahb_uart_fifo;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_irq;
    string       name;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic nReset;
  logic rx_drv;
  logic loop_en;
  logic rx;
  logic tx;
  logic irq;

  assign rx = loop_en ? tx : rx_drv;

  bus_protocol_if bp ();

  ahb_uart_fifo #(
    .DEFAULT_RATE(16'd5207),
    .RX_DEPTH(16),
    .TX_DEPTH(16)
  ) dut (
    .clk(clk),
    .nReset(nReset),
    .rx(rx),
    .tx(tx),
    .irq(irq),
    .bp(bp)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d, output logic e);
    @(negedge clk);
    bp.addr = a; bp.ren = 1'b1; bp.wen = 1'b0; bp.strobe = 4'h0; bp.wdata = 32'h0;
    #1;
    d = bp.rdata;
    e = bp.error;
    @(posedge clk);
    #1;
    bp.ren = 1'b0;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] w, input logic [3:0] s,
                        output logic [31:0] d, output logic e);
    @(negedge clk);
    bp.addr = a; bp.ren = 1'b0; bp.wen = 1'b1; bp.strobe = s; bp.wdata = w;
    #1;
    d = bp.rdata;
    e = bp.error;
    @(posedge clk);
    #1;
    bp.wen = 1'b0;
  endtask

  task automatic get_frame(output logic [7:0] b, output logic stop_bit, output logic timed_out);
    int n;
    n = 0; b = 8'h00; stop_bit = 1'b0; timed_out = 1'b0;
    @(negedge clk);
    while (tx !== 1'b0 && n < 3000) begin @(negedge clk); n++; end
    if (tx !== 1'b0) begin timed_out = 1'b1; return; end
    repeat (7) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      repeat (16) @(negedge clk);
      b[i] = tx;
    end
    repeat (16) @(negedge clk);
    stop_bit = tx;
  endtask

  task automatic count_tx_low(input int cycles, output int lows);
    lows = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic [31:0] a, input logic [31:0] w,
                              input logic [3:0] s, input logic [31:0] er, input logic ee,
                              input logic ei, input string nm);
    vec_t v;
    v.wr = wr; v.addr = a; v.wdata = w; v.strb = s;
    v.exp_rdata = er; v.exp_err = ee; v.exp_irq = ei; v.name = nm;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  vec_t        vecs [16];
  logic [31:0] d;
  logic        e;
  logic [7:0]  b;
  logic        sb, tmo;
  int          n, lows;

  initial begin
    vecs[0]  = mk(0, 32'h00, 32'h0,         4'h0, 32'h0000_0005, 0, 0, "rst_status");
    vecs[1]  = mk(0, 32'h04, 32'h0,         4'h0, 32'h0003_1457, 0, 0, "rst_ctrl");
    vecs[2]  = mk(0, 32'h10, 32'h0,         4'h0, 32'h0000_0000, 0, 0, "rst_irq_en");
    vecs[3]  = mk(0, 32'h14, 32'h0,         4'h0, 32'h0000_0002, 0, 0, "rst_irq_stat");
    vecs[4]  = mk(0, 32'h08, 32'h0,         4'h0, 32'h8000_0000, 0, 0, "rxdata_empty");
    vecs[5]  = mk(0, 32'h18, 32'h0,         4'h0, 32'h0000_0000, 1, 0, "unmapped_rd");
    vecs[6]  = mk(1, 32'h1C, 32'h0000_FFFF, 4'hF, 32'h0000_0000, 1, 0, "unmapped_wr");
    vecs[7]  = mk(1, 32'h04, 32'h0003_0000, 4'hF, 32'h0000_0000, 0, 0, "ctrl_wr_rate0");
    vecs[8]  = mk(0, 32'h04, 32'h0,         4'h0, 32'h0003_0001, 0, 0, "ctrl_rate0_is_1");
    vecs[9]  = mk(1, 32'h04, 32'hFFFF_FF10, 4'h1, 32'h0000_0000, 0, 0, "ctrl_wr_byte0");
    vecs[10] = mk(0, 32'h04, 32'h0,         4'h0, 32'h0003_0010, 0, 0, "ctrl_rate16");
    vecs[11] = mk(1, 32'h10, 32'h0000_0002, 4'h1, 32'h0000_0000, 0, 1, "irq_en_txidle");
    vecs[12] = mk(0, 32'h10, 32'h0,         4'h0, 32'h0000_0002, 0, 1, "irq_en_rd");
    vecs[13] = mk(1, 32'h10, 32'h0000_0000, 4'h1, 32'h0000_0000, 0, 0, "irq_en_clr");
    vecs[14] = mk(1, 32'h00, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000, 0, 0, "status_ro_wr");
    vecs[15] = mk(0, 32'h00, 32'h0,         4'h0, 32'h0000_0005, 0, 0, "status_after_wr");

    nReset = 1'b0; rx_drv = 1'b1; loop_en = 1'b0;
    bp.addr = 32'h0; bp.wdata = 32'h0; bp.strobe = 4'h0; bp.ren = 1'b0; bp.wen = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx", {31'b0, tx}, 32'd1);
    check("rst_irq", {31'b0, irq}, 32'd0);
    nReset = 1'b1;

    for (int i = 0; i < 16; i++) begin
      if (vecs[i].wr) bus_wr(vecs[i].addr, vecs[i].wdata, vecs[i].strb, d, e);
      else            bus_rd(vecs[i].addr, d, e);
      check({vecs[i].name, "_rdata"}, d, vecs[i].exp_rdata);
      check({vecs[i].name, "_err"}, {31'b0, e}, {31'b0, vecs[i].exp_err});
      check({vecs[i].name, "_irq"}, {31'b0, irq}, {31'b0, vecs[i].exp_irq});
    end

    // Two frames at 16 clk/bit, decoded from the line.
    bus_wr(32'h0C, 32'h41, 4'h1, d, e);
    bus_wr(32'h0C, 32'h42, 4'h1, d, e);
    get_frame(b, sb, tmo);
    check("frame1_timeout", {31'b0, tmo}, 32'd0);
    check("frame1_byte", {24'b0, b}, 32'h41);
    check("frame1_stop", {31'b0, sb}, 32'd1);
    get_frame(b, sb, tmo);
    check("frame2_byte", {24'b0, b}, 32'h42);
    check("frame2_stop", {31'b0, sb}, 32'd1);
    repeat (16) @(negedge clk);
    bus_rd(32'h00, d, e);
    check("status_after_tx", d, 32'h0000_0005);

    // Loopback fill of the RX FIFO.
    loop_en = 1'b1;
    for (int i = 0; i < 16; i++) bus_wr(32'h0C, 32'(i), 4'h1, d, e);
    n = 0;
    do begin bus_rd(32'h00, d, e); n++; end while (d[31:24] != 8'd16 && n < 4000);
    check("rx_count_reached", {24'b0, d[31:24]}, 32'd16);
    repeat (30) @(negedge clk);
    bus_rd(32'h00, d, e);
    check("status_rx_full", d, 32'h1000_0006);

    // Overflow of the RX FIFO and its interrupt.
    bus_wr(32'h10, 32'h08, 4'h1, d, e);
    check("irq_before_ovf", {31'b0, irq}, 32'd0);
    bus_wr(32'h0C, 32'h10, 4'h1, d, e);
    repeat (200) @(negedge clk);
    bus_rd(32'h14, d, e);
    check("irq_stat_rx_ovf", d, 32'h0000_000B);
    check("irq_on_rx_ovf", {31'b0, irq}, 32'd1);
    bus_wr(32'h14, 32'h08, 4'h1, d, e);
    check("irq_after_w1c", {31'b0, irq}, 32'd0);
    bus_rd(32'h14, d, e);
    check("irq_stat_after_w1c", d, 32'h0000_0003);

    // RXDATA read in the same cycle the engine delivers a byte into a full FIFO.
    bus_wr(32'h0C, 32'h20, 4'h1, d, e);
    n = 0;
    @(negedge clk);
    while (dut.rx_done !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    check("rx_done_seen", {31'b0, dut.rx_done}, 32'd1);
    bp.addr = 32'h08; bp.ren = 1'b1;
    #1;
    d = bp.rdata;
    @(posedge clk);
    #1;
    bp.ren = 1'b0;
    check("same_cycle_head", d, 32'h0000_0000);
    repeat (30) @(negedge clk);
    bus_rd(32'h00, d, e);
    check("same_cycle_status", d, 32'h1000_0006);
    bus_rd(32'h14, d, e);
    check("same_cycle_no_ovf", d, 32'h0000_0003);

    // Drain in order, then one read past empty.
    for (int i = 0; i < 16; i++) begin
      bus_rd(32'h08, d, e);
      check($sformatf("drain_%0d", i), d, (i < 15) ? 32'(i + 1) : 32'h20);
    end
    bus_rd(32'h08, d, e);
    check("drain_past_empty", d, 32'h8000_0000);
    bus_rd(32'h00, d, e);
    check("status_drained", d, 32'h0000_0005);

    // TX overflow with the transmitter disabled, then flush.
    loop_en = 1'b0;
    bus_wr(32'h04, 32'h0001_0010, 4'hF, d, e);
    for (int i = 0; i < 17; i++) bus_wr(32'h0C, 32'hA0 + 32'(i), 4'h1, d, e);
    bus_rd(32'h00, d, e);
    check("status_tx_full", d, 32'h0010_0009);
    bus_rd(32'h14, d, e);
    check("irq_stat_tx_ovf", d, 32'h0000_0010);
    count_tx_low(50, lows);
    check("no_frame_tx_dis", 32'(lows), 32'd0);
    bus_wr(32'h04, 32'h0009_0010, 4'hF, d, e);
    bus_rd(32'h00, d, e);
    check("status_after_flush", d, 32'h0000_0005);
    bus_rd(32'h04, d, e);
    check("ctrl_flush_reads0", d, 32'h0001_0010);
    bus_wr(32'h04, 32'h0003_0010, 4'hF, d, e);
    count_tx_low(300, lows);
    check("no_frame_after_flush", 32'(lows), 32'd0);
    bus_wr(32'h14, 32'h10, 4'h1, d, e);
    bus_rd(32'h14, d, e);
    check("tx_ovf_cleared", d, 32'h0000_0002);

    // Busy flag mid-frame, then reset abandons the frame.
    bus_wr(32'h0C, 32'h55, 4'h1, d, e);
    n = 0;
    @(negedge clk);
    while (tx !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    check("frame3_started", {31'b0, tx}, 32'd0);
    bus_rd(32'h00, d, e);
    check("status_busy", d, 32'h0000_0015);
    @(negedge clk);
    nReset = 1'b0;
    @(negedge clk);
    check("tx_high_in_reset", {31'b0, tx}, 32'd1);
    nReset = 1'b1;
    bus_rd(32'h04, d, e);
    check("ctrl_after_reset", d, 32'h0003_1457);
    bus_rd(32'h00, d, e);
    check("status_after_reset", d, 32'h0000_0005);
    bus_rd(32'h14, d, e);
    check("irq_stat_after_reset", d, 32'h0000_0002);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
